// File: rtl/hist_run_sched.sv
// hist_run_sched: run scheduler gating an LFSR stream into a FIFO for a fixed
// number of beats, waiting for the pipeline to drain, then launching a RAM readout.
//   aclk, aresetn           clock, async active-low reset
//   start, abort            run request (IDLE only) / run cancel (non-IDLE)
//   cfg_samples             beats per run, latched on an accepted start
//   s_axis_*                LFSR stream in;  m_axis_* gated stream out to FIFO
//   pipe_idle               FIFO empty and histogram quiet
//   rd_start, rd_done       readout launch pulse / readout complete pulse
//   busy, done, state       status: non-IDLE, completion pulse, current state
//   sample_cnt              beats accepted in the current/last run
module hist_run_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CNT_WIDTH-1:0]  cfg_samples,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  pipe_idle,
   output logic                  rd_start,
   input  logic                  rd_done,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            state,
   output logic [CNT_WIDTH-1:0]  sample_cnt
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_STREAM  = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_READOUT = 2'd3;
   logic [1:0]           r_state;
   logic [1:0]           w_next;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_target;
   logic                 r_busy;
   logic                 r_rd_start;
   logic                 r_done;
   logic                 w_stream;
   logic                 w_hs;
   logic                 w_last;
   logic                 w_accept;
   assign w_stream = r_state == S_STREAM;
   assign w_hs     = w_stream & s_axis_tvalid & m_axis_tready;
   // target is never zero while streaming, so target-1 cannot underflow
   assign w_last   = r_cnt == r_target - CNT_WIDTH'(1);
   assign w_accept = (r_state == S_IDLE) & start & (|cfg_samples);
   // abort outranks every non-IDLE transition
   always_comb begin
      w_next = r_state;
      if (r_state == S_IDLE)
         w_next = w_accept ? S_STREAM : S_IDLE;
      else if (abort)
         w_next = S_IDLE;
      else if (r_state == S_STREAM)
         w_next = (w_hs && w_last) ? S_DRAIN : S_STREAM;
      else if (r_state == S_DRAIN)
         w_next = pipe_idle ? S_READOUT : S_DRAIN;
      else
         w_next = rd_done ? S_IDLE : S_READOUT;
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_target   <= '0;
         r_busy     <= 1'b0;
         r_rd_start <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_busy     <= w_next != S_IDLE;
         r_rd_start <= (r_state == S_DRAIN) && (w_next == S_READOUT);
         r_done     <= (r_state == S_READOUT) && (w_next == S_IDLE) && !abort;
         if (w_accept) begin
            r_cnt    <= '0;
            r_target <= cfg_samples;
         end else if (w_hs) begin
            r_cnt    <= r_cnt + CNT_WIDTH'(1);
         end
      end
   end
   // the gate is a pure combinational pass-through while streaming
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tvalid = w_stream & s_axis_tvalid;
   assign s_axis_tready = w_stream & m_axis_tready;
   assign rd_start      = r_rd_start;
   assign done          = r_done;
   assign busy          = r_busy;
   assign state         = r_state;
   assign sample_cnt    = r_cnt;
endmodule

// File: tb/tb_hist_run_sched.sv
// tb_hist_run_sched: randomized and directed check of hist_run_sched against a run-level reference model.
module tb_hist_run_sched;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic        start, abort, s_axis_tvalid, m_axis_tready, pipe_idle, rd_done;
   logic [15:0] cfg_samples;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tready, m_axis_tvalid, rd_start, busy, done;
   logic [31:0] m_axis_tdata;
   logic [1:0]  state;
   logic [15:0] sample_cnt;
   int n_chk = 0, n_fail = 0;
   int n_beats, n_rds, n_done;
   int m_ph, m_cnt, m_tgt, m_rds, m_dn;
   always #5 aclk = ~aclk;
   hist_run_sched dut (
      .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
      .cfg_samples(cfg_samples), .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .pipe_idle(pipe_idle),
      .rd_start(rd_start), .rd_done(rd_done), .busy(busy), .done(done),
      .state(state), .sample_cnt(sample_cnt)
   );
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_ph = 0; m_cnt = 0; m_tgt = 0; m_rds = 0; m_dn = 0;
   endtask
   task automatic clr_counts();
      n_beats = 0; n_rds = 0; n_done = 0;
   endtask
   // one clock: drive, check mid-cycle against the model, advance the model
   task automatic cyc(input logic st, input logic ab, input logic [15:0] cs,
                      input logic tv, input logic tr, input logic pi, input logic rdd);
      logic open, hs;
      start = st; abort = ab; cfg_samples = cs; s_axis_tvalid = tv;
      m_axis_tready = tr; pipe_idle = pi; rd_done = rdd; s_axis_tdata = $urandom;
      #4;
      open = (m_ph == 1);
      check("state", 32'(state), 32'(m_ph));
      check("busy", 32'(busy), 32'(m_ph != 0));
      check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
      check("rd_start", 32'(rd_start), 32'(m_rds));
      check("done", 32'(done), 32'(m_dn));
      check("m_tvalid", 32'(m_axis_tvalid), 32'(open & tv));
      check("s_tready", 32'(s_axis_tready), 32'(open & tr));
      if (open && tv) check("m_tdata", m_axis_tdata, s_axis_tdata);
      if (m_axis_tvalid && m_axis_tready) n_beats++;
      if (rd_start) n_rds++;
      if (done) n_done++;
      hs = open && tv && tr;
      m_rds = 0; m_dn = 0;
      if (hs) m_cnt++;
      if (m_ph == 0) begin
         if (st && cs != 0) begin m_ph = 1; m_tgt = int'(cs); m_cnt = 0; end
      end else if (ab) m_ph = 0;
      else if (m_ph == 1 && hs && m_cnt == m_tgt) m_ph = 2;
      else if (m_ph == 2 && pi) begin m_ph = 3; m_rds = 1; end
      else if (m_ph == 3 && rdd) begin m_ph = 0; m_dn = 1; end
      @(posedge aclk); #1;
   endtask
   initial begin
      aresetn = 1'b0; start = 0; abort = 0; cfg_samples = 0; s_axis_tdata = 0;
      s_axis_tvalid = 1; m_axis_tready = 1; pipe_idle = 0; rd_done = 0;
      model_reset();
      #2;
      check("rst_state", 32'(state), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_cnt", 32'(sample_cnt), 0);
      check("rst_tvalid", 32'(m_axis_tvalid), 0);
      check("rst_tready", 32'(s_axis_tready), 0);
      @(posedge aclk); @(posedge aclk); #1;
      aresetn = 1'b1;
      cyc(0,0,0,1,1,0,0);
      // 5 beats with both sides always ready
      clr_counts();
      cyc(1,0,5,1,1,0,0);
      for (int i = 0; i < 5; i++) cyc(0,0,9,1,1,0,0);
      check("t37_beats", 32'(n_beats), 5);
      check("t37_state", 32'(state), 2);
      check("t37_cnt", 32'(sample_cnt), 5);
      cyc(1,0,7,1,1,0,0);
      cyc(0,1,0,1,1,0,0);
      // 4 beats with toggling FIFO ready, then drain and readout
      clr_counts();
      cyc(1,0,4,1,1,0,0);
      for (int i = 0; i < 8; i++) cyc(0,0,0,1,(i % 2) == 0,0,0);
      cyc(0,0,0,1,1,0,0);
      cyc(0,0,0,1,1,0,0);
      cyc(0,0,0,1,1,1,0);
      for (int i = 0; i < 6; i++) cyc(0,0,0,1,1,0,0);
      cyc(0,0,0,1,1,0,1);
      cyc(0,0,0,1,1,0,0);
      cyc(0,0,0,1,1,0,0);
      check("t38_beats", 32'(n_beats), 4);
      check("t38_rd_start", 32'(n_rds), 1);
      check("t38_done", 32'(n_done), 1);
      check("t38_state", 32'(state), 0);
      // zero-length request is ignored
      clr_counts();
      cyc(1,0,0,1,1,1,1);
      for (int i = 0; i < 3; i++) cyc(0,0,0,1,1,1,1);
      check("t39_state", 32'(state), 0);
      check("t39_beats", 32'(n_beats), 0);
      check("t39_done", 32'(n_done), 0);
      // abort in DRAIN beats a same-cycle pipe_idle
      clr_counts();
      cyc(1,0,1,1,1,0,0);
      cyc(0,0,0,1,1,0,0);
      cyc(0,1,0,1,1,1,0);
      for (int i = 0; i < 3; i++) cyc(0,0,0,1,1,1,0);
      check("t40_rd_start", 32'(n_rds), 0);
      check("t40_state", 32'(state), 0);
      // abort coincident with the 2nd handshake still counts that beat
      clr_counts();
      cyc(1,0,3,1,1,0,0);
      cyc(0,0,0,1,1,0,0);
      cyc(0,1,0,1,1,0,0);
      cyc(0,0,0,1,1,0,0);
      check("t41_cnt", 32'(sample_cnt), 2);
      check("t41_state", 32'(state), 0);
      check("t41_done", 32'(n_done), 0);
      check("t41_beats", 32'(n_beats), 2);
      // asynchronous reset while in READOUT
      clr_counts();
      cyc(1,0,1,1,1,0,0);
      cyc(0,0,0,1,1,0,0);
      cyc(0,0,0,1,1,1,0);
      check("t42_pre_state", 32'(state), 3);
      #2;
      aresetn = 1'b0;
      #1;
      check("t42_state", 32'(state), 0);
      check("t42_busy", 32'(busy), 0);
      check("t42_rd_start", 32'(rd_start), 0);
      check("t42_done", 32'(done), 0);
      check("t42_cnt", 32'(sample_cnt), 0);
      check("t42_tvalid", 32'(m_axis_tvalid), 0);
      check("t42_tready", 32'(s_axis_tready), 0);
      model_reset();
      @(posedge aclk); #1;
      aresetn = 1'b1;
      for (int i = 0; i < 3; i++) cyc(0,0,0,1,1,1,1);
      check("t42_late_done", 32'(n_done), 0);
      // randomized traffic against the model
      clr_counts();
      for (int i = 0; i < 1500; i++)
         cyc($urandom_range(0,3) == 0, $urandom_range(0,24) == 0, 16'($urandom_range(0,6)),
             1'($urandom), 1'($urandom), $urandom_range(0,2) == 0, $urandom_range(0,3) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hist_run_sched.md
HIST_RUN_SCHED -- requirements
Module: hist_run_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of sample target and counter.
REQ-003 SHALL have port aclk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  run request, sampled level, acted on in IDLE only.
REQ-006 SHALL have port abort  input  1  run cancel, acted on in any non-IDLE state.
REQ-007 SHALL have port cfg_samples  input  CNT_WIDTH  samples per run, latched at start.
REQ-008 SHALL have port s_axis_tdata  input  DATA_WIDTH  LFSR stream data.
REQ-009 SHALL have port s_axis_tvalid  input  1  LFSR stream valid.
REQ-010 SHALL have port s_axis_tready  output  1  ready back to LFSR.
REQ-011 SHALL have port m_axis_tdata  output  DATA_WIDTH  gated stream to FIFO.
REQ-012 SHALL have port m_axis_tvalid  output  1  gated valid to FIFO.
REQ-013 SHALL have port m_axis_tready  input  1  FIFO ready.
REQ-014 SHALL have port pipe_idle  input  1  high when FIFO empty and histogram not accumulating.
REQ-015 SHALL have port rd_start  output  1  one-cycle pulse launching RAM readout.
REQ-016 SHALL have port rd_done  input  1  RAM readout complete pulse.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse on normal run completion.
REQ-019 SHALL have port state  output  2  IDLE=0, STREAM=1, DRAIN=2, READOUT=3.
REQ-020 SHALL have port sample_cnt  output  CNT_WIDTH  beats accepted this run.

Function
REQ-021 IDLE: m_axis_tvalid=0, s_axis_tready=0; LFSR stalled.
REQ-022 IDLE, start=1, cfg_samples!=0: latch target=cfg_samples, sample_cnt<=0, next state STREAM.
REQ-023 IDLE, start=1, cfg_samples==0: ignored, stay IDLE, no done.
REQ-024 STREAM: combinational pass-through -- m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready; zero latency, no buffering.
REQ-025 STREAM: sample_cnt increments by 1 on each cycle with s_axis_tvalid&&m_axis_tready.
REQ-026 STREAM: handshake when sample_cnt==target-1 -> DRAIN next cycle; exactly target beats pass, gate closed from that cycle on.
REQ-027 DRAIN: gate closed as IDLE; pipe_idle=1 -> READOUT next cycle with rd_start=1 for exactly that first READOUT cycle.
REQ-028 READOUT: gate closed; rd_done=1 -> IDLE next cycle with done=1 for one cycle.
REQ-029 rd_done outside READOUT SHALL be ignored.
REQ-030 start in any non-IDLE state SHALL be ignored; cfg_samples changes after latch SHALL not affect the run.
REQ-031 abort=1 in STREAM/DRAIN/READOUT: IDLE next cycle, highest priority over all other transitions; no done, no rd_start.
REQ-032 abort coincident with a STREAM handshake: the beat is transferred and counted, then IDLE.
REQ-033 sample_cnt SHALL hold its final value in IDLE until next accepted start; no wrap (max target 2^CNT_WIDTH-1).
REQ-034 busy, state, rd_start, done SHALL be registered outputs.

Reset
REQ-035 aresetn=0 asynchronously: state=IDLE, sample_cnt=0, target=0, rd_start=0, done=0, busy=0, m_axis_tvalid=0, s_axis_tready=0.
REQ-036 Reset mid-run SHALL discard the run with no done or rd_start pulse; operation resumes on first clock after deassertion.

Verification
REQ-037 cfg_samples=5, start, tvalid/tready held 1 -> exactly 5 beats out, STREAM 5 cycles, sample_cnt=5, DRAIN.
REQ-038 cfg_samples=4, m_axis_tready toggled 1010..., pipe_idle after 3 cycles, rd_done 7 cycles later -> 4 beats, one rd_start, one done, back to IDLE.
REQ-039 start with cfg_samples=0 -> state stays 0, no beats, no done.
REQ-040 abort in DRAIN with pipe_idle=1 same cycle -> IDLE, rd_start never asserted.
REQ-041 cfg_samples=3, abort on 2nd handshake -> sample_cnt=2, IDLE, no done.
REQ-042 aresetn low during READOUT -> all outputs at reset values same cycle; later rd_done ignored.
